census_hamming_sweep: RTL and testbench

- Parametrised, sequential successor to the combinational census/Hamming stage of the DisparityMap path.
- Latches one reference window and the matching candidate row strips, then sweeps NUM_DISP disparities through LANES parallel census+Hamming lanes over NUM_DISP/LANES cycles.
- Emits the full cost vector plus a winner-take-all minimum (cost and disparity) through a valid/ready handshake to the downstream aggregation/WTA stage.

---
 rtl/census_hamming_sweep.sv | 168 ++++++++++++++++
 tb/tb_census_hamming_sweep.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/census_hamming_sweep.sv
// rtl/census_hamming_sweep.sv - census/Hamming disparity cost sweep over LANES-wide groups with winner-take-all minimum
module census_hamming_sweep #(
    parameter int PIX_W    = 11,
    parameter int WIN      = 3,
    parameter int NUM_DISP = 256,
    parameter int LANES    = 64,
    parameter int HD_W     = 4,
    parameter int DISP_W   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [WIN*WIN*PIX_W-1:0]                ref_win,
    input  logic [WIN*(NUM_DISP+WIN-1)*PIX_W-1:0]   cand_rows,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [NUM_DISP*HD_W-1:0]                out_cost,
    output logic [HD_W-1:0]                         out_min_cost,
    output logic [DISP_W-1:0]                       out_min_disp
);

    localparam int NPIX  = WIN * WIN;
    localparam int CW    = NPIX - 1;
    localparam int CTR   = NPIX / 2;
    localparam int STRIP = NUM_DISP + WIN - 1;
    localparam int G     = NUM_DISP / LANES;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [GW-1:0]               g_q;
    logic [CW-1:0]               ref_census_q;
    logic [WIN*STRIP*PIX_W-1:0]  cand_q;
    logic [HD_W-1:0]             min_cost_q;
    logic [DISP_W-1:0]           min_disp_q;
    logic [NPIX*PIX_W-1:0]       lane_win [LANES];
    logic [HD_W-1:0]             lane_cost [LANES];
    logic [HD_W-1:0]             grp_min_cost;
    logic [DISP_W-1:0]           grp_min_disp;

    // Census bit order is row-major with the centre pixel removed.
    function automatic logic [CW-1:0] census(input logic [NPIX*PIX_W-1:0] w);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NPIX; i++) begin
            if (i < CTR) begin
                c[i] = w[i*PIX_W +: PIX_W] < w[CTR*PIX_W +: PIX_W];
            end else if (i > CTR) begin
                c[i-1] = w[i*PIX_W +: PIX_W] < w[CTR*PIX_W +: PIX_W];
            end
        end
        return c;
    endfunction

    function automatic logic [HD_W-1:0] popcount(input logic [CW-1:0] x);
        logic [HD_W-1:0] n;
        n = '0;
        for (int i = 0; i < CW; i++) begin
            n = n + HD_W'(x[i]);
        end
        return n;
    endfunction

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_win[l] = '0;
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    lane_win[l][(r*WIN+c)*PIX_W +: PIX_W] =
                        cand_q[(r*STRIP + int'(g_q)*LANES + l + c)*PIX_W +: PIX_W];
                end
            end
            lane_cost[l] = popcount(census(lane_win[l]) ^ ref_census_q);
        end
    end

    // Strict less-than with ascending lanes keeps the lowest disparity on ties.
    always_comb begin
        grp_min_cost = min_cost_q;
        grp_min_disp = min_disp_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_cost[l] < grp_min_cost) begin
                grp_min_cost = lane_cost[l];
                grp_min_disp = DISP_W'(int'(g_q)*LANES + l);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (g_q == GW'(G-1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q          <= '0;
            ref_census_q <= '0;
            cand_q       <= '0;
            out_cost     <= '0;
            min_cost_q   <= '0;
            min_disp_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cand_q       <= cand_rows;
                        ref_census_q <= census(ref_win);
                        g_q          <= '0;
                        min_cost_q   <= '1;
                        min_disp_q   <= '0;
                    end
                end
                SWEEP: begin
                    for (int l = 0; l < LANES; l++) begin
                        out_cost[(int'(g_q)*LANES + l)*HD_W +: HD_W] <= lane_cost[l];
                    end
                    min_cost_q <= grp_min_cost;
                    min_disp_q <= grp_min_disp;
                    if (g_q != GW'(G-1)) begin
                        g_q <= g_q + GW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_min_cost = min_cost_q;
    assign out_min_disp = min_disp_q;

endmodule

// File: tb/tb_census_hamming_sweep.sv
// tb/tb_census_hamming_sweep.sv - scoreboard bench for census_hamming_sweep
module tb_census_hamming_sweep;

    localparam int PIX_W    = 11;
    localparam int WIN      = 3;
    localparam int NUM_DISP = 256;
    localparam int LANES    = 64;
    localparam int HD_W     = 4;
    localparam int DISP_W   = 8;
    localparam int G        = NUM_DISP / LANES;
    localparam int STRIP    = NUM_DISP + WIN - 1;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           in_valid;
    logic                           in_ready;
    logic [WIN*WIN*PIX_W-1:0]       ref_win;
    logic [WIN*STRIP*PIX_W-1:0]     cand_rows;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_DISP*HD_W-1:0]       out_cost;
    logic [HD_W-1:0]                out_min_cost;
    logic [DISP_W-1:0]              out_min_disp;

    typedef struct {
        logic [NUM_DISP*HD_W-1:0] cost;
        logic [HD_W-1:0]          minc;
        logic [DISP_W-1:0]        mind;
        int                       cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   first = 1'b1;
    int   ec [NUM_DISP];

    census_hamming_sweep #(
        .PIX_W(PIX_W), .WIN(WIN), .NUM_DISP(NUM_DISP),
        .LANES(LANES), .HD_W(HD_W), .DISP_W(DISP_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ref_win(ref_win), .cand_rows(cand_rows), .out_valid(out_valid),
        .out_ready(out_ready), .out_cost(out_cost), .out_min_cost(out_min_cost),
        .out_min_disp(out_min_disp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_cost(input string name, input logic [NUM_DISP*HD_W-1:0] exp);
        n_vec++;
        if (out_cost !== exp) begin
            n_bad++;
            for (int d = 0; d < NUM_DISP; d++) begin
                if (out_cost[d*HD_W +: HD_W] !== exp[d*HD_W +: HD_W]) begin
                    $display("FAIL %s cost[%0d]: got %0d expected %0d", name, d,
                             out_cost[d*HD_W +: HD_W], exp[d*HD_W +: HD_W]);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("ready_valid_excl", 64'(in_ready), 64'd0);
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_result: out_valid=1 with no request pending");
            end else begin
                if (first) begin
                    check("latency", 64'(cyc), 64'(q[0].cyc));
                    first = 1'b0;
                end
                check_cost("result", q[0].cost);
                check("min_cost", 64'(out_min_cost), 64'(q[0].minc));
                check("min_disp", 64'(out_min_disp), 64'(q[0].mind));
                if (out_ready) begin
                    void'(q.pop_front());
                    first = 1'b1;
                end
            end
        end
    end

    task automatic set_ref(input int centre, input int neigh);
        for (int i = 0; i < WIN*WIN; i++)
            ref_win[i*PIX_W +: PIX_W] = PIX_W'((i == (WIN*WIN)/2) ? centre : neigh);
    endtask

    task automatic set_cand_all(input int v);
        for (int i = 0; i < WIN*STRIP; i++) cand_rows[i*PIX_W +: PIX_W] = PIX_W'(v);
    endtask

    task automatic set_cand(input int r, input int e, input int v);
        cand_rows[(r*STRIP + e)*PIX_W +: PIX_W] = PIX_W'(v);
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < WIN*WIN; i++) ref_win[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 3));
        for (int i = 0; i < WIN*STRIP; i++) cand_rows[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 3));
    endtask

    // Six neighbours below a centre of 90, two right-column corners above it: cost 2 vs ref census 0xFF.
    task automatic craft_cost2(input int d);
        set_cand(0, d, 10);  set_cand(0, d+1, 10); set_cand(0, d+2, 200);
        set_cand(1, d, 10);  set_cand(1, d+1, 90); set_cand(1, d+2, 10);
        set_cand(2, d, 10);  set_cand(2, d+1, 10); set_cand(2, d+2, 200);
    endtask

    task automatic fill_ec(input int v);
        for (int d = 0; d < NUM_DISP; d++) ec[d] = v;
    endtask

    function automatic int pref(input int r, input int c);
        return int'(ref_win[(r*WIN + c)*PIX_W +: PIX_W]);
    endfunction

    function automatic int pcand(input int r, input int e);
        return int'(cand_rows[(r*STRIP + e)*PIX_W +: PIX_W]);
    endfunction

    task automatic model(output int minc, output int mind);
        int cr, cost;
        bit rb, cb;
        cr = WIN / 2;
        minc = 1 << HD_W;
        mind = 0;
        for (int d = 0; d < NUM_DISP; d++) begin
            cost = 0;
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    if (!(r == cr && c == cr)) begin
                        rb = pref(r, c) < pref(cr, cr);
                        cb = pcand(r, d + c) < pcand(cr, d + cr);
                        if (rb != cb) cost++;
                    end
                end
            end
            ec[d] = cost;
            if (cost < minc) begin
                minc = cost;
                mind = d;
            end
        end
    endtask

    task automatic send(input int minc, input int mind, input bit expect_out, input bit keep, output int t);
        exp_t e;
        bit   got;
        got = 1'b0;
        t = -1;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles");
        end else begin
            t = cyc;
            if (expect_out) begin
                for (int d = 0; d < NUM_DISP; d++) e.cost[d*HD_W +: HD_W] = HD_W'(ec[d]);
                e.minc = HD_W'(minc);
                e.mind = DISP_W'(mind);
                e.cyc  = t + G + 1;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: %0d results still pending", name, q.size());
        end
    endtask

    initial begin
        int t, minc, mind;
        int ts [5];
        bit seen;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ref_win = '0;
        cand_rows = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check_cost("rst", '0);
        check("rst_min_cost", 64'(out_min_cost), 64'd0);
        check("rst_min_disp", 64'(out_min_disp), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Flat image
        set_ref(100, 100);
        set_cand_all(100);
        fill_ec(0);
        send(0, 0, 1'b1, 1'b0, t);

        // Single match at d=37; windows 35 and 39 see three dark pixels
        set_ref(100, 50);
        set_cand_all(200);
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) set_cand(r, 37 + c, (r == 1 && c == 1) ? 90 : 10);
        fill_ec(8);
        ec[35] = 5; ec[37] = 0; ec[39] = 5;
        send(0, 37, 1'b1, 1'b0, t);

        // Tie across groups: d=10 and d=200
        set_ref(100, 50);
        set_cand_all(200);
        craft_cost2(10);
        craft_cost2(200);
        fill_ec(8);
        ec[8] = 5;   ec[10] = 2;  ec[12] = 7;
        ec[198] = 5; ec[200] = 2; ec[202] = 7;
        send(2, 10, 1'b1, 1'b0, t);

        // Tie inside one group: d=70 and d=71
        set_ref(100, 50);
        set_cand_all(200);
        set_cand(0, 70, 10); set_cand(0, 71, 10);  set_cand(0, 72, 200); set_cand(0, 73, 10);
        set_cand(1, 70, 10); set_cand(1, 71, 100); set_cand(1, 72, 150); set_cand(1, 73, 10);
        set_cand(2, 70, 10); set_cand(2, 71, 10);  set_cand(2, 72, 10);  set_cand(2, 73, 200);
        fill_ec(8);
        ec[68] = 5; ec[70] = 2; ec[71] = 2; ec[73] = 6;
        send(2, 70, 1'b1, 1'b0, t);
        wait_drain("drain_ties");

        // Backpressure with in_valid and inputs churning while DONE
        @(posedge clk);
        #1 out_ready = 1'b0;
        set_ref(100, 50);
        set_cand_all(200);
        craft_cost2(10);
        craft_cost2(200);
        fill_ec(8);
        ec[8] = 5;   ec[10] = 2;  ec[12] = 7;
        ec[198] = 5; ec[200] = 2; ec[202] = 7;
        send(2, 10, 1'b1, 1'b0, t);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL bp_timeout: out_valid never rose");
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            randomize_inputs();
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_popped", 64'(q.size()), 64'd0);

        // Reset during group 2 aborts the request
        @(posedge clk);
        #1 randomize_inputs();
        send(0, 0, 1'b0, 1'b0, t);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check_cost("abort", '0);
        check("abort_min_cost", 64'(out_min_cost), 64'd0);
        check("abort_min_disp", 64'(out_min_disp), 64'd0);
        @(posedge clk);
        #1;
        set_ref(100, 50);
        set_cand_all(200);
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) set_cand(r, 37 + c, (r == 1 && c == 1) ? 90 : 10);
        fill_ec(8);
        ec[35] = 5; ec[37] = 0; ec[39] = 5;
        send(0, 37, 1'b1, 1'b0, t);
        wait_drain("drain_abort");

        // Streaming: back-to-back requests against the model
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            randomize_inputs();
            model(minc, mind);
            send(minc, mind, 1'b1, 1'b1, ts[i]);
        end
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) check("stream_interval", 64'(ts[i] - ts[i-1]), 64'(G + 2));
        wait_drain("drain_stream");
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
